cla_pipe_adder: RTL

// - Parametrised, pipelined successor to the 4-bit CLA adder: WIDTH-bit add of A+B+in.
// - Built from 4-bit CLA groups (group G/P, carry lookahead inside a group).
// - GPS groups are resolved per pipeline stage; the inter-stage carry is registered.
// - Valid/ready handshake on both sides; throughput of one operation per cycle.
// - Sits in the datapath wherever a wide adder must meet timing.

---
 rtl/cla_pipe_adder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder built from 4-bit CLA groups, GPS groups resolved per stage.
// Optional subtract mode (sub port, A + ~B + 1) is enabled by defining CLA_SUB_EN.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             G,
  output logic             P,
  output logic             V
);

  localparam int STAGES = WIDTH / (4 * GPS);

  generate
    if ((WIDTH % (4 * GPS)) != 0 || WIDTH < 4 * GPS) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*GPS");
    end
  endgenerate

  logic sub_w;
`ifdef CLA_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Index 0 is the input capture; index j+1 holds the result of resolving stage j.
  logic [STAGES:0]                vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [STAGES:0][WIDTH-1:0]     s_q, s_d;
  logic [STAGES:0]                cy_q, cy_d, g_q, g_d, p_q, p_d, cm_q, cm_d;
  logic                           en;

  assign en       = !vld_q[STAGES] || out_ready;
  assign in_ready = en;

  always_comb begin
    logic       c, blk_g, blk_p, cm;
    logic [3:0] nib_a, nib_b, gi, pi;
    logic       c1, c2, c3, gg, pp;
    int         grp;
    c = 1'b0; blk_g = 1'b0; blk_p = 1'b0; cm = 1'b0;
    nib_a = '0; nib_b = '0; gi = '0; pi = '0;
    c1 = 1'b0; c2 = 1'b0; c3 = 1'b0; gg = 1'b0; pp = 1'b0;
    grp = 0;
    vld_d = vld_q; a_d = a_q; b_d = b_q; s_d = s_q;
    cy_d = cy_q; g_d = g_q; p_d = p_q; cm_d = cm_q;
    if (en) begin
      // Block G/P start at the identity (G=0, P=1) so the first group combines cleanly.
      vld_d[0] = in_valid;
      a_d[0]   = A;
      b_d[0]   = B ^ {WIDTH{sub_w}};
      s_d[0]   = '0;
      cy_d[0]  = sub_w | in;
      g_d[0]   = 1'b0;
      p_d[0]   = 1'b1;
      cm_d[0]  = 1'b0;
      for (int j = 1; j < STAGES; j++) begin
        a_d[j] = a_q[j-1];
        b_d[j] = b_q[j-1];
      end
      for (int j = 0; j < STAGES; j++) begin
        vld_d[j+1] = vld_q[j];
        s_d[j+1]   = s_q[j];
        c          = cy_q[j];
        blk_g      = g_q[j];
        blk_p      = p_q[j];
        cm         = cm_q[j];
        for (int k = 0; k < GPS; k++) begin
          grp   = j * GPS + k;
          nib_a = a_q[j][grp*4 +: 4];
          nib_b = b_q[j][grp*4 +: 4];
          gi    = nib_a & nib_b;
          pi    = nib_a ^ nib_b;
          c1    = gi[0] | (pi[0] & c);
          c2    = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c);
          c3    = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & c);
          gg    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
          pp    = &pi;
          s_d[j+1][grp*4 +: 4] = pi ^ {c3, c2, c1, c};
          cm    = c3;
          c     = gg | (pp & c);
          blk_g = gg | (pp & blk_g);
          blk_p = pp & blk_p;
        end
        cy_d[j+1] = c;
        g_d[j+1]  = blk_g;
        p_d[j+1]  = blk_p;
        cm_d[j+1] = cm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      cy_q  <= '0;
      g_q   <= '0;
      p_q   <= '0;
      cm_q  <= '0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      cy_q  <= cy_d;
      g_q   <= g_d;
      p_q   <= p_d;
      cm_q  <= cm_d;
    end
  end

  // cm holds the carry into the MSB, captured while the top group was resolved.
  assign out_valid = vld_q[STAGES];
  assign S         = s_q[STAGES];
  assign C         = cy_q[STAGES];
  assign G         = g_q[STAGES];
  assign P         = p_q[STAGES];
  assign V         = cm_q[STAGES] ^ cy_q[STAGES];

endmodule
